// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the gpio_irq peripheral: register map, address type
// and width limits.
package gpio_irq_pkg;

  localparam int GPIO_W_MAX = 32;
  localparam int ADDR_W     = 3;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_GPI  = 3'd0;
  localparam addr_t ADDR_GPO  = 3'd1;
  localparam addr_t ADDR_GPD  = 3'd2;
  localparam addr_t ADDR_SET  = 3'd3;
  localparam addr_t ADDR_CLR  = 3'd4;
  localparam addr_t ADDR_RISE = 3'd5;
  localparam addr_t ADDR_FALL = 3'd6;
  localparam addr_t ADDR_PEND = 3'd7;

  // GPO_SET and GPO_CLR are write-only strobes; everything else that is not
  // GPI holds readable state.
  function automatic logic is_write_only(input addr_t a);
    return (a == ADDR_SET) || (a == ADDR_CLR);
  endfunction

endpackage

// File: rtl/gpio_irq_sync.sv
// Input synchroniser chain for the GPIO pins plus a one-cycle delayed copy of
// the synchronised value, from which single-cycle rise/fall pulses are derived.
module gpio_irq_sync
  import gpio_irq_pkg::*;
#(
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [GPIO_W-1:0] gpi,
  output logic [GPIO_W-1:0] s,
  output logic [GPIO_W-1:0] rise,
  output logic [GPIO_W-1:0] fall
);

  logic [SYNC_STAGES-1:0][GPIO_W-1:0] chain;
  logic [GPIO_W-1:0]                  p;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      chain <= '0;
      p     <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], gpi};
      p     <= chain[SYNC_STAGES-1];
    end
  end

  assign s = chain[SYNC_STAGES-1];

  // p holds s from the previous cycle, so each transition yields one pulse.
  assign rise = s & ~p;
  assign fall = ~s & p;

endmodule

// File: rtl/gpio_irq.sv
// Parametrised GPIO peripheral: Avalon-MM register file, atomic GPO set/clear,
// and per-pin edge interrupt capture ORed onto a single level irq.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [GPIO_W-1:0] gpio_gpi,
  output logic [GPIO_W-1:0] gpio_gpo,
  output logic [GPIO_W-1:0] gpio_gpd,
  output logic              irq
);

  // Bus handshake: avs_write and avs_read are single-cycle strobes with no
  // wait states. A write takes effect on the edge that samples it. A read is
  // answered exactly one cycle later by a one-cycle avs_readdatavalid pulse;
  // avs_readdata holds its value between reads. When both strobes coincide
  // the read returns the contents from before the write.

  addr_t             addr;
  logic [GPIO_W-1:0] wd;
  logic [GPIO_W-1:0] s;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] fall;

  logic [GPIO_W-1:0] gpo_q;
  logic [GPIO_W-1:0] gpd_q;
  logic [GPIO_W-1:0] rise_en_q;
  logic [GPIO_W-1:0] fall_en_q;
  logic [GPIO_W-1:0] pend_q;
  logic [GPIO_W-1:0] pend_clr;
  logic [GPIO_W-1:0] pend_set;
  logic [GPIO_W-1:0] rd_sel;
  logic [31:0]       rd_word;

  assign addr = addr_t'(avs_address);
  assign wd   = avs_writedata[GPIO_W-1:0];

  if (GPIO_W < 32) begin : g_unused_wd
    logic unused_wd_hi;
    assign unused_wd_hi = ^avs_writedata[31:GPIO_W];
  end

  gpio_irq_sync #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .gpi         (gpio_gpi),
    .s           (s),
    .rise        (rise),
    .fall        (fall)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      gpo_q     <= '0;
      gpd_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (avs_write) begin
      case (addr)
        ADDR_GPO:  gpo_q     <= wd;
        ADDR_SET:  gpo_q     <= gpo_q | wd;
        ADDR_CLR:  gpo_q     <= gpo_q & ~wd;
        ADDR_GPD:  gpd_q     <= wd;
        ADDR_RISE: rise_en_q <= wd;
        ADDR_FALL: fall_en_q <= wd;
        default:   ;
      endcase
    end
  end

  // A new enabled edge wins over a clear of the same bit in the same cycle.
  always_comb begin
    pend_clr = '0;
    if (avs_write && (addr == ADDR_PEND)) begin
      pend_clr = wd;
    end
    pend_set = (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  always_comb begin
    rd_sel = '0;
    if (!is_write_only(addr)) begin
      case (addr)
        ADDR_GPI:  rd_sel = s;
        ADDR_GPO:  rd_sel = gpo_q;
        ADDR_GPD:  rd_sel = gpd_q;
        ADDR_RISE: rd_sel = rise_en_q;
        ADDR_FALL: rd_sel = fall_en_q;
        ADDR_PEND: rd_sel = pend_q;
        default:   rd_sel = '0;
      endcase
    end
    rd_word = 32'(rd_sel);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_word;
      end
    end
  end

  assign gpio_gpo = gpo_q;
  assign gpio_gpd = gpd_q;
  assign irq      = |pend_q;

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised GPIO peripheral with an Avalon-MM slave register port and interrupt logic. It is the next-generation replacement for the fixed 8-bit GPIO in the ORCA system.
- Width is configurable.
- Inputs are synchronised.
- GPO supports atomic set/clear writes.
- Each pin has rising- and falling-edge interrupt capture, ORed onto one level interrupt line to the CPU.

## Interface
- GPIO_W, 8, pin count (1..32)
- SYNC_STAGES, 2, input synchroniser depth (≥2)

- clk_clk  in  1  system clock
- reset_reset  in  1  reset; one clock, reset is synchronous and active-high
- avs_address  in  3  word address
- avs_write  in  1  write strobe, single cycle
- avs_writedata  in  32  write data; bits [GPIO_W-1:0] used, rest ignored
- avs_read  in  1  read strobe, single cycle
- avs_readdata  out  32  read data, zero-extended above GPIO_W
- avs_readdatavalid  out  1  high one cycle after avs_read
- gpio_gpi  in  GPIO_W  asynchronous pin inputs
- gpio_gpo  out  GPIO_W  output values
- gpio_gpd  out  GPIO_W  direction, 1 = output enable
- irq  out  1  level interrupt, high while any pending bit is set

## Operation
Register map (word addresses):
- 0 GPI: RO, synchronised inputs.
- 1 GPO: RW.
- 2 GPD: RW.
- 3 GPO_SET: WO, GPO |= data. Reads 0.
- 4 GPO_CLR: WO, GPO &= ~data. Reads 0.
- 5 RISE_EN: RW.
- 6 FALL_EN: RW.
- 7 PEND: RW1C.

Rules:
- Writes to RO addresses are ignored.
- Reads of WO addresses return 0.
- avs_read and avs_write asserted together: the write executes and the read returns pre-write contents.

Edge detection:
- Per bit, s = last synchroniser stage and p = s delayed one cycle.
- rise = s & ~p; fall = ~s & p.
- PEND[i] next = (PEND[i] & ~clr[i]) | (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- clr is the W1C write data at address 7.
- A new edge in the same cycle as its clear: the set wins and the bit stays 1.
- Enables gate the setting of PEND only. Clearing an enable does not clear an already-pending bit.
- irq = |PEND. It is a combinational OR of registered bits, with no further register.

Reset values:
- All registers, synchroniser flops, p flops, avs_readdata, avs_readdatavalid and irq are 0.
- gpio_gpo = 0 and gpio_gpd = 0, so all pins are inputs after reset.
- A pin held high through reset produces a rise event SYNC_STAGES+1 cycles after reset. RISE_EN is 0 at that point, so no PEND is set.
- Reset asserted mid-operation clears everything on the next edge, including in-flight read data.

## Timing
- Register writes update on the edge that samples avs_write. gpio_gpo and gpio_gpd show the new value immediately after that edge.
- Reads use fixed latency 1: avs_readdata and avs_readdatavalid are registered on the edge sampling avs_read. readdatavalid is 0 otherwise, and readdata holds its last value.
- Back-to-back reads every cycle are supported.
- A pin change arriving before edge k is visible in GPI after edge k+SYNC_STAGES-1.
- PEND sets, and irq rises, after edge k+SYNC_STAGES.
- A PEND clear write drops irq after the write edge, provided no other bit is pending and no new enabled edge occurs in the same cycle.
- Pulses shorter than one clock period may be missed. Only transitions seen by the synchroniser count.

## Structure
- Package gpio_irq_pkg holds:
  - address localparams: ADDR_GPI, ADDR_GPO, ADDR_GPD, ADDR_SET, ADDR_CLR, ADDR_RISE, ADDR_FALL, ADDR_PEND;
  - the 3-bit address typedef;
  - a GPIO_W_MAX = 32 constant.
- Sub-module gpio_irq_sync:
  - parametrised GPIO_W and SYNC_STAGES;
  - contains the synchroniser chain plus the p flop;
  - outputs s, rise and fall.
- Top level holds the register file, readback mux and PEND logic.

## Test plan
- Reset, then read all 8 addresses → all read 0. gpio_gpo = 0, gpio_gpd = 0, irq = 0.
- GPO sequence (GPIO_W = 8): write GPO = 0xA5, write SET = 0x0A, write CLR = 0x81 → gpio_gpo = 0xA5, then 0xAF, then 0x2E. Readback of GPO matches each value. Readback of SET/CLR is 0.
- RISE_EN = 0x01, FALL_EN = 0x02. Drive gpio_gpi 0x00→0x03 → PEND = 0x01 and irq high exactly SYNC_STAGES+1 edges after the change. Then drive 0x03→0x00 → PEND = 0x03.
- PEND = 0x03, write PEND = 0x01 → PEND = 0x02 and irq stays high. Write 0x02 → irq low the next cycle.
- Clear PEND[0] in the same cycle a new enabled rise on pin 0 is detected → PEND[0] remains 1.
- GPIO_W = 32, SYNC_STAGES = 3 build: write 0xFFFF_FFFF to GPD → readback 0xFFFF_FFFF. GPI latency becomes 3 edges. Reset asserted mid-read → avs_readdatavalid = 0 and all registers 0 on the next edge.
